// File: rtl/dff_pipe_hs.sv
// Elastic D-flip-flop pipeline: DEPTH stages of WIDTH-bit registers with
// valid/ready handshake, bubble collapse, synchronous clear and occupancy count.
module dff_pipe_hs #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           DEPTH     = 3,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qb,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [DEPTH-1:0] ONES = '1;

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_rdy;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Stage g can load when some stage at or downstream of it is empty, or the
    // consumer drains; the low mask ignores stages upstream of g.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        localparam logic [DEPTH-1:0] LOW = ONES >> (DEPTH - g);
        assign w_rdy[g] = out_ready | ~(&(r_valid | LOW));
    end

    assign in_ready   = w_rdy[0] & ~clr & rst;
    assign out_valid  = r_valid[DEPTH-1] & ~clr;
    assign q          = r_data[DEPTH-1];
    assign qb         = ~r_data[DEPTH-1];
    assign count      = r_count;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Data only moves with a valid word, so empty-stage data stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            if (w_rdy[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= d;
                end
            end
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

endmodule

// File: tb/tb_dff_pipe_hs.sv
// Directed self-checking bench for dff_pipe_hs at WIDTH=8, DEPTH=3, RESET_VAL=0.
module tb_dff_pipe_hs;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] q;
    logic [7:0] qb;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] count;

    int n_vec;
    int n_err;

    dff_pipe_hs #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .qb        (qb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] val);
        d        = val;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        clr       = 1'b0;
        d         = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_q",      32'(q),         32'h00);
        check("rst_qb",     32'(qb),        32'hFF);
        check("rst_ovalid", 32'(out_valid), 32'h0);
        check("rst_count",  32'(count),     32'h0);
        check("rst_iready", 32'(in_ready),  32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rel_iready", 32'(in_ready), 32'h1);

        // Streaming
        out_ready = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("str_q0",   32'(q),         32'h11);
        check("str_ov0",  32'(out_valid), 32'h1);
        check("str_cnt0", 32'(count),     32'h3);
        idle();
        check("str_q1",   32'(q),     32'h22);
        check("str_cnt1", 32'(count), 32'h2);
        idle();
        check("str_q2", 32'(q), 32'h33);
        idle();
        check("str_empty_ov", 32'(out_valid), 32'h0);
        check("str_empty_q",  32'(q),         32'h33);
        check("str_empty_c",  32'(count),     32'h0);

        // Async reset mid-stream
        out_ready = 1'b0;
        push(8'h77);
        push(8'h78);
        check("mid_cnt", 32'(count), 32'h2);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mid_rst_q",   32'(q),         32'h00);
        check("mid_rst_qb",  32'(qb),        32'hFF);
        check("mid_rst_ov",  32'(out_valid), 32'h0);
        check("mid_rst_cnt", 32'(count),     32'h0);
        check("mid_rst_ir",  32'(in_ready),  32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rel_ir", 32'(in_ready), 32'h1);

        // Backpressure
        out_ready = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("bp_cnt", 32'(count),    32'h3);
        check("bp_ir",  32'(in_ready), 32'h0);
        push(8'hA4);
        check("bp_hold_cnt", 32'(count), 32'h3);
        check("bp_hold_q",   32'(q),     32'hA1);
        out_ready = 1'b1;
        #1;
        check("bp_ir_rel", 32'(in_ready), 32'h1);
        tick();
        check("bp_q2",  32'(q),     32'hA2);
        check("bp_c2",  32'(count), 32'h3);
        idle();
        check("bp_q3",  32'(q), 32'hA3);
        idle();
        check("bp_q4",  32'(q),         32'hA4);
        check("bp_qb4", 32'(qb),        32'h5B);
        check("bp_ov4", 32'(out_valid), 32'h1);
        idle();
        check("bp_end_ov", 32'(out_valid), 32'h0);

        // Full with simultaneous in/out
        out_ready = 1'b0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("full_cnt", 32'(count), 32'h3);
        out_ready = 1'b1;
        d         = 8'h5C;
        in_valid  = 1'b1;
        #1;
        check("full_ir", 32'(in_ready), 32'h1);
        tick();
        check("full_cnt2", 32'(count), 32'h3);
        check("full_q",    32'(q),     32'h42);
        idle();
        idle();
        check("full_5c",    32'(q),         32'h5C);
        check("full_5c_ov", 32'(out_valid), 32'h1);
        idle();
        check("full_end_c", 32'(count), 32'h0);

        // Synchronous clear
        out_ready = 1'b0;
        push(8'h61);
        idle();
        idle();
        push(8'h62);
        check("clr_pre_cnt", 32'(count),     32'h2);
        check("clr_pre_ov",  32'(out_valid), 32'h1);
        clr       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        d         = 8'h63;
        #1;
        check("clr_ir", 32'(in_ready),  32'h0);
        check("clr_ov", 32'(out_valid), 32'h0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clr_cnt", 32'(count),     32'h0);
        check("clr_q",   32'(q),         32'h00);
        check("clr_qb",  32'(qb),        32'hFF);
        check("clr_ov2", 32'(out_valid), 32'h0);

        // Bubble collapse
        out_ready = 1'b0;
        push(8'h01);
        idle();
        push(8'h02);
        idle();
        check("bub_cnt", 32'(count),     32'h2);
        check("bub_q",   32'(q),         32'h01);
        check("bub_ov",  32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        check("bub_q2",  32'(q),         32'h02);
        check("bub_ov2", 32'(out_valid), 32'h1);
        tick();
        check("bub_end_ov", 32'(out_valid), 32'h0);
        check("bub_end_c",  32'(count),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
